// File: rtl/store_combine_drain.sv
// Store drain stage: pops committed stores from a show-ahead FIFO, merges
// consecutive stores to the same doubleword into one held entry, and issues
// the merged write to the data-memory bus.
//
// Bus handshake: o_req_valid/o_req_addr/o_req_data/o_req_mask are held
// constant while o_req_valid=1 until i_req_ack=1; a request is transferred on
// any cycle where both o_req_valid and i_req_ack are 1. i_req_ack is ignored
// while o_req_valid=0.
module store_combine_drain #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 4,
  localparam int EW     = AW + 69
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_fifo_empty,
  input  logic [EW-1:0] i_fifo_data,
  output logic          o_fifo_rd,
  input  logic          i_flush,
  output logic          o_req_valid,
  output logic [AW-1:0] o_req_addr,
  output logic [63:0]   o_req_data,
  output logic [7:0]    o_req_mask,
  input  logic          i_req_ack,
  output logic          o_drained,
  output logic [1:0]    o_dbg_state
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int DW = AW - 3;
  localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   buf_addr_q, buf_addr_d;
  logic [7:0]      buf_mask_q, buf_mask_d;
  logic [63:0]     buf_data_q, buf_data_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            req_valid_q;

  logic [DW-1:0]   head_addr;
  logic [7:0]      head_mask;
  logic [63:0]     head_data;
  logic [63:0]     merge_data;
  logic [TW-1:0]   timer_inc;

  assign head_addr = i_fifo_data[EW-1:72];
  assign head_mask = i_fifo_data[71:64];
  assign head_data = i_fifo_data[63:0];

  // Per-byte merge: bytes enabled by the newer head entry replace held bytes.
  always_comb begin
    merge_data = buf_data_q;
    for (int b = 0; b < 8; b++) begin
      if (head_mask[b]) merge_data[b*8 +: 8] = head_data[b*8 +: 8];
    end
  end

  // Saturating HOLD-cycle counter increment.
  assign timer_inc = (timer_q == TIMEOUT_V) ? timer_q : timer_q + TW'(1);

  // Next-state, buffer update and pop strobe.
  always_comb begin
    state_d    = state_q;
    buf_addr_d = buf_addr_q;
    buf_mask_d = buf_mask_q;
    buf_data_d = buf_data_q;
    timer_d    = timer_q;
    o_fifo_rd  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!i_fifo_empty) begin
          o_fifo_rd  = 1'b1;
          buf_addr_d = head_addr;
          buf_mask_d = head_mask;
          buf_data_d = head_data;
          timer_d    = '0;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (i_flush || timer_q == TIMEOUT_V) begin
          state_d = ST_ISSUE;
        end else if (!i_fifo_empty && head_addr == buf_addr_q) begin
          o_fifo_rd  = 1'b1;
          buf_mask_d = buf_mask_q | head_mask;
          buf_data_d = merge_data;
          timer_d    = timer_inc;
        end else if (!i_fifo_empty) begin
          state_d = ST_ISSUE;
        end else begin
          timer_d = timer_inc;
        end
      end
      ST_ISSUE: begin
        if (i_req_ack) begin
          if (!i_fifo_empty) begin
            o_fifo_rd  = 1'b1;
            buf_addr_d = head_addr;
            buf_mask_d = head_mask;
            buf_data_d = head_data;
            timer_d    = '0;
            state_d    = ST_HOLD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Reset wins: the FIFO must not advance during a reset cycle.
    if (i_reset) o_fifo_rd = 1'b0;
  end

  // State, buffer, timer and request-valid registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      buf_addr_q  <= '0;
      buf_mask_q  <= '0;
      buf_data_q  <= '0;
      timer_q     <= '0;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_addr_q  <= buf_addr_d;
      buf_mask_q  <= buf_mask_d;
      buf_data_q  <= buf_data_d;
      timer_q     <= timer_d;
      req_valid_q <= (state_d == ST_ISSUE);
    end
  end

  assign o_req_valid = req_valid_q;
  assign o_req_addr  = {buf_addr_q, 3'b000};
  assign o_req_data  = buf_data_q;
  assign o_req_mask  = buf_mask_q;
  assign o_drained   = (state_q == ST_IDLE) && i_fifo_empty;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_store_combine_drain.sv
// Bench for store_combine_drain: queue-backed FIFO model on the read side,
// scoreboard of expected bus requests checked at every accepted request.
module tb_store_combine_drain;

  localparam int AW      = 32;
  localparam int TIMEOUT = 4;
  localparam int EW      = AW + 69;
  localparam int RW      = AW + 72;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  logic          i_clk;
  logic          i_reset;
  logic          i_fifo_empty;
  logic [EW-1:0] i_fifo_data;
  logic          o_fifo_rd;
  logic          i_flush;
  logic          o_req_valid;
  logic [AW-1:0] o_req_addr;
  logic [63:0]   o_req_data;
  logic [7:0]    o_req_mask;
  logic          i_req_ack;
  logic          o_drained;
  logic [1:0]    o_dbg_state;

  logic [EW-1:0] fifo_q[$];
  logic [RW-1:0] exp_q[$];

  int   total;
  int   bad;
  logic rd_seen;
  logic ack_en;

  store_combine_drain #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_fifo_empty (i_fifo_empty),
    .i_fifo_data  (i_fifo_data),
    .o_fifo_rd    (o_fifo_rd),
    .i_flush      (i_flush),
    .o_req_valid  (o_req_valid),
    .o_req_addr   (o_req_addr),
    .o_req_data   (o_req_data),
    .o_req_mask   (o_req_mask),
    .i_req_ack    (i_req_ack),
    .o_drained    (o_drained),
    .o_dbg_state  (o_dbg_state)
  );

  // Clock and reset
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  function automatic logic [EW-1:0] make_entry(input logic [AW-1:0] a,
                                               input logic [7:0] m,
                                               input logic [63:0] d);
    return {a[AW-1:3], m, d};
  endfunction

  function automatic logic [RW-1:0] make_req(input logic [AW-1:0] a,
                                             input logic [7:0] m,
                                             input logic [63:0] d);
    return {a, m, d};
  endfunction

  // Driver tasks
  task automatic drive_head();
    i_fifo_empty = (fifo_q.size() == 0);
    i_fifo_data  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
    if (rd_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
    drive_head();
    i_req_ack = ack_en & o_req_valid;
  endtask

  task automatic wait_drained(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (o_drained === 1'b1 && o_req_valid === 1'b0) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  // Scoreboard / monitor, sampled on the falling edge
  always @(negedge i_clk) begin
    logic [RW-1:0] got;
    logic [RW-1:0] exp;
    rd_seen = o_fifo_rd;
    if (o_fifo_rd === 1'b1) begin
      total++;
      if (i_fifo_empty !== 1'b0) begin
        bad++;
        $display("FAIL pop_when_empty got empty=%b required 0", i_fifo_empty);
      end
    end
    if (o_req_valid === 1'b1 && i_req_ack === 1'b1) begin
      got = {o_req_addr, o_req_mask, o_req_data};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_req got=%h required none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          bad++;
          $display("FAIL req_payload got=%h required=%h", got, exp);
        end
      end
    end
  end

  task automatic test_reset();
    step();
    step();
    total++;
    if (o_req_valid !== 1'b0 || o_dbg_state !== S_IDLE) begin
      bad++;
      $display("FAIL reset_state got valid=%b state=%0d required 0/0", o_req_valid, o_dbg_state);
    end
    total++;
    if ({o_req_addr, o_req_mask, o_req_data} !== '0) begin
      bad++;
      $display("FAIL reset_payload got=%h required 0", {o_req_addr, o_req_mask, o_req_data});
    end
    total++;
    if (o_drained !== 1'b1 || o_fifo_rd !== 1'b0) begin
      bad++;
      $display("FAIL reset_drained got drained=%b rd=%b required 1/0", o_drained, o_fifo_rd);
    end
    fifo_q.push_back(make_entry(32'h0000_0100, 8'hFF, 64'h1));
    drive_head();
    #1;
    total++;
    if (o_fifo_rd !== 1'b0 || o_drained !== 1'b0) begin
      bad++;
      $display("FAIL reset_gates_pop got rd=%b drained=%b required 0/0", o_fifo_rd, o_drained);
    end
    fifo_q.delete();
    drive_head();
    i_reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    int  k;
    bit  found;
    bit  ok;
    logic [63:0] d;
    d = 64'h1122_3344_5566_7788;
    ack_en = 1'b1;
    fifo_q.push_back(make_entry(32'h0000_1000, 8'h0F, d));
    exp_q.push_back(make_req(32'h0000_1000, 8'h0F, d));
    drive_head();
    #1;
    total++;
    if (o_fifo_rd !== 1'b1) begin
      bad++;
      $display("FAIL single_pop got rd=%b required 1", o_fifo_rd);
    end
    found = 1'b0;
    k = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      step();
      if (o_req_valid === 1'b1) begin
        found = 1'b1;
        k = i;
      end
    end
    total++;
    if (k != 2 + TIMEOUT) begin
      bad++;
      $display("FAIL single_latency got=%0d required=%0d", k, 2 + TIMEOUT);
    end
    step();
    total++;
    if (o_drained !== 1'b1 || o_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_drained got drained=%b valid=%b required 1/0", o_drained, o_req_valid);
    end
    wait_drained(ok);
    total++;
    if (!ok || exp_q.size() != 0) begin
      bad++;
      $display("FAIL single_done got ok=%b left=%0d required 1/0", ok, exp_q.size());
    end
  endtask

  task automatic test_merge();
    bit ok;
    logic [63:0] d4;
    d4 = {$urandom(), $urandom()};
    ack_en = 1'b1;
    fifo_q.push_back(make_entry(32'h0000_2008, 8'h01, 64'h1111_2222_3333_44AA));
    fifo_q.push_back(make_entry(32'h0000_2008, 8'h02, 64'hFFFF_FFFF_FFFF_BBFF));
    fifo_q.push_back(make_entry(32'h0000_2008, 8'h01, 64'h9999_9999_9999_99CC));
    fifo_q.push_back(make_entry(32'h0000_3000, 8'hFF, d4));
    exp_q.push_back(make_req(32'h0000_2008, 8'h03, 64'h1111_2222_3333_BBCC));
    exp_q.push_back(make_req(32'h0000_3000, 8'hFF, d4));
    drive_head();
    step();
    wait_drained(ok);
    total++;
    if (!ok || exp_q.size() != 0) begin
      bad++;
      $display("FAIL merge_done got ok=%b left=%0d required 1/0", ok, exp_q.size());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    ack_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [7:0] bv;
      bv = 8'h10 + 8'(i);
      fifo_q.push_back(make_entry(32'h0000_4000, 8'h01 << i, {8{bv}}));
    end
    exp_q.push_back(make_req(32'h0000_4000, 8'h1F, 64'h1010_1014_1312_1110));
    exp_q.push_back(make_req(32'h0000_4000, 8'h20, 64'h1515_1515_1515_1515));
    drive_head();
    step();
    wait_drained(ok);
    total++;
    if (!ok || exp_q.size() != 0 || fifo_q.size() != 0) begin
      bad++;
      $display("FAIL timeout_done got ok=%b left=%0d fifo=%0d required 1/0/0", ok, exp_q.size(), fifo_q.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int k;
    logic [63:0] da;
    logic [RW-1:0] req_a;
    da = {$urandom(), $urandom()};
    req_a = make_req(32'h0000_5000, 8'hFF, da);
    ack_en = 1'b0;
    fifo_q.push_back(make_entry(32'h0000_5000, 8'hFF, da));
    exp_q.push_back(req_a);
    for (int i = 1; i < 4; i++) begin
      logic [AW-1:0] a;
      logic [63:0]   d;
      a = 32'h0000_5000 + 32'(8 * i);
      d = {$urandom(), $urandom()};
      fifo_q.push_back(make_entry(a, 8'hF0, d));
      exp_q.push_back(make_req(a, 8'hF0, d));
    end
    drive_head();
    k = 0;
    for (int i = 1; i <= 10 && k == 0; i++) begin
      step();
      if (o_req_valid === 1'b1) k = i;
    end
    total++;
    if (k != 2) begin
      bad++;
      $display("FAIL bp_issue_latency got=%0d required=2", k);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if ({o_req_addr, o_req_mask, o_req_data} !== req_a || o_req_valid !== 1'b1 ||
          o_fifo_rd !== 1'b0 || fifo_q.size() != 3) begin
        bad++;
        $display("FAIL bp_hold got=%h v=%b rd=%b fifo=%0d required=%h 1/0/3",
                 {o_req_addr, o_req_mask, o_req_data}, o_req_valid, o_fifo_rd, fifo_q.size(), req_a);
      end
    end
    ack_en = 1'b1;
    i_req_ack = 1'b1;
    #1;
    total++;
    if (o_fifo_rd !== 1'b1) begin
      bad++;
      $display("FAIL bp_ack_pop got rd=%b required 1", o_fifo_rd);
    end
    step();
    total++;
    if (o_dbg_state !== S_HOLD || o_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_after_ack got state=%0d valid=%b required 1/0", o_dbg_state, o_req_valid);
    end
    wait_drained(ok);
    total++;
    if (!ok || exp_q.size() != 0) begin
      bad++;
      $display("FAIL bp_done got ok=%b left=%0d required 1/0", ok, exp_q.size());
    end
  endtask

  task automatic test_flush();
    bit ok;
    logic [63:0] dx;
    logic [63:0] dy;
    dx = {$urandom(), $urandom()};
    dy = {$urandom(), $urandom()};
    ack_en = 1'b1;
    fifo_q.push_back(make_entry(32'h0000_6000, 8'h01, dx));
    fifo_q.push_back(make_entry(32'h0000_6000, 8'h10, dy));
    exp_q.push_back(make_req(32'h0000_6000, 8'h01, dx));
    exp_q.push_back(make_req(32'h0000_6000, 8'h10, dy));
    drive_head();
    step();
    i_flush = 1'b1;
    #1;
    total++;
    if (o_fifo_rd !== 1'b0 || o_dbg_state !== S_HOLD) begin
      bad++;
      $display("FAIL flush_no_merge got rd=%b state=%0d required 0/1", o_fifo_rd, o_dbg_state);
    end
    step();
    total++;
    if (o_dbg_state !== S_ISSUE || o_req_valid !== 1'b1 || o_req_mask !== 8'h01) begin
      bad++;
      $display("FAIL flush_issue got state=%0d valid=%b mask=%h required 2/1/01",
               o_dbg_state, o_req_valid, o_req_mask);
    end
    step();
    i_flush = 1'b0;
    wait_drained(ok);
    total++;
    if (!ok || exp_q.size() != 0) begin
      bad++;
      $display("FAIL flush_done got ok=%b left=%0d required 1/0", ok, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    int t[4];
    ack_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [AW-1:0] a;
      logic [63:0]   d;
      logic [7:0]    m;
      a = 32'h0000_8000 + 32'(8 * i);
      d = {$urandom(), $urandom()};
      m = (i == 2) ? 8'h00 : 8'($urandom_range(1, 255));
      fifo_q.push_back(make_entry(a, m, d));
      exp_q.push_back(make_req(a, m, d));
    end
    drive_head();
    n = 0;
    for (int k = 1; k <= 40 && n < 4; k++) begin
      step();
      if (o_req_valid === 1'b1 && i_req_ack === 1'b1) begin
        t[n] = k;
        n++;
      end
    end
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL b2b_count got=%0d required=4", n);
    end else begin
      total++;
      if (t[1] - t[0] != 2 || t[2] - t[1] != 2 || t[3] - t[2] != TIMEOUT + 2) begin
        bad++;
        $display("FAIL b2b_spacing got=%0d,%0d,%0d required=2,2,%0d",
                 t[1] - t[0], t[2] - t[1], t[3] - t[2], TIMEOUT + 2);
      end
    end
    wait_drained(ok);
    total++;
    if (!ok || exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_done got ok=%b left=%0d required 1/0", ok, exp_q.size());
    end
  endtask

  task automatic test_reset_issue();
    bit ok;
    int k;
    logic [63:0] dg;
    dg = {$urandom(), $urandom()};
    ack_en = 1'b0;
    fifo_q.push_back(make_entry(32'h0000_7000, 8'hFF, {$urandom(), $urandom()}));
    fifo_q.push_back(make_entry(32'h0000_7008, 8'h3C, dg));
    drive_head();
    k = 0;
    for (int i = 1; i <= 10 && k == 0; i++) begin
      step();
      if (o_req_valid === 1'b1) k = i;
    end
    total++;
    if (k == 0) begin
      bad++;
      $display("FAIL rst_issue_reach got valid=%b required 1", o_req_valid);
    end
    i_reset = 1'b1;
    #1;
    total++;
    if (o_fifo_rd !== 1'b0) begin
      bad++;
      $display("FAIL rst_no_pop got rd=%b required 0", o_fifo_rd);
    end
    step();
    total++;
    if (o_req_valid !== 1'b0 || o_dbg_state !== S_IDLE ||
        {o_req_addr, o_req_mask, o_req_data} !== '0) begin
      bad++;
      $display("FAIL rst_drop got valid=%b state=%0d payload=%h required 0/0/0",
               o_req_valid, o_dbg_state, {o_req_addr, o_req_mask, o_req_data});
    end
    i_reset = 1'b0;
    ack_en = 1'b1;
    exp_q.push_back(make_req(32'h0000_7008, 8'h3C, dg));
    step();
    wait_drained(ok);
    total++;
    if (!ok || exp_q.size() != 0 || fifo_q.size() != 0) begin
      bad++;
      $display("FAIL rst_done got ok=%b left=%0d fifo=%0d required 1/0/0", ok, exp_q.size(), fifo_q.size());
    end
  endtask

  // Test sequence and final report
  initial begin
    total     = 0;
    bad       = 0;
    rd_seen   = 1'b0;
    ack_en    = 1'b0;
    i_reset   = 1'b1;
    i_flush   = 1'b0;
    i_req_ack = 1'b0;
    drive_head();
    test_reset();
    test_single();
    test_merge();
    test_timeout();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_reset_issue();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
